// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor3_bist_ctrl.sv
// Built-in self-test sequencer for a single NOR3 cell instance.
// Sweeps A1..A3 through all eight vectors, lets each settle, samples ZN,
// and accumulates a saturating mismatch count plus the first failing vector.
module gf180mcu_fd_sc_mcu9t5v0__nor3_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ITERATIONS    = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [2:0]       FAIL_VEC
);

    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned ITER_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [SET_W-1:0]  SET_RELOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(ITERATIONS - 1);
    localparam logic [CNT_W-1:0]  ERR_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        vec;
    logic [SET_W-1:0]  settle_cnt;
    logic [ITER_W-1:0] iter_cnt;

    logic              mismatch;
    logic              last_vec;
    logic [CNT_W-1:0]  err_next;

    // Cell inputs come straight from the vector register.
    assign A1 = vec[0];
    assign A2 = vec[1];
    assign A3 = vec[2];

    // Sample evaluation: a NOR3 output is high only for the all-zero vector.
    always_comb begin
        mismatch = 1'b0;
        last_vec = 1'b0;
        err_next = ERR_CNT;
        mismatch = (ZN != (vec == 3'd0));
        last_vec = (vec == 3'd7) && (iter_cnt == ITER_LAST);
        if (mismatch && (ERR_CNT != ERR_MAX)) begin
            err_next = ERR_CNT + CNT_W'(1);
        end
    end

    // Sequencer: state, vector stepping, result capture and status outputs.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle_cnt <= '0;
            iter_cnt   <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VLD   <= 1'b0;
            FAIL_VEC   <= 3'd0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && !ABORT) begin
                        vec        <= 3'd0;
                        settle_cnt <= SET_RELOAD;
                        iter_cnt   <= '0;
                        ERR_CNT    <= '0;
                        FAIL_VLD   <= 1'b0;
                        FAIL_VEC   <= 3'd0;
                        PASS       <= 1'b0;
                        BUSY       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (ABORT) begin
                        vec   <= 3'd0;
                        BUSY  <= 1'b0;
                        PASS  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                SAMPLE: begin
                    if (ABORT) begin
                        vec   <= 3'd0;
                        BUSY  <= 1'b0;
                        PASS  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ERR_CNT <= err_next;
                        if (mismatch && !FAIL_VLD) begin
                            FAIL_VEC <= vec;
                            FAIL_VLD <= 1'b1;
                        end
                        if (last_vec) begin
                            // FIN outputs are loaded on entry so they are visible during FIN.
                            vec   <= 3'd0;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            PASS  <= (err_next == '0);
                            state <= FIN;
                        end else begin
                            vec        <= vec + 3'd1;
                            settle_cnt <= SET_RELOAD;
                            if (vec == 3'd7) begin
                                iter_cnt <= iter_cnt + ITER_W'(1);
                            end
                            state <= SETTLE;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
